// File: rtl/alu_exec_unit_if.sv
// Request/response bundle for alu_exec_unit: valid/ready operation request in,
// valid/ready result with zero and illegal flags out.
interface alu_exec_unit_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      ALU_ctrl;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  modport master (
    output in_valid, ALU_ctrl, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, ALU_ctrl, operand_a, operand_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// AND/OR/ADD/SUB execution unit with a registered result and a main+skid
// output buffer so in_ready never depends combinationally on out_ready.
module alu_exec_unit #(
  parameter int XLEN = 64
) (
  input logic          clk,
  input logic          rst,
  alu_exec_unit_if.slave bus
);

  logic            r_valid_q, r_valid_d;
  logic [XLEN-1:0] r_result_q, r_result_d;
  logic            r_zero_q, r_zero_d;
  logic            r_illegal_q, r_illegal_d;
  logic            s_valid_q, s_valid_d;
  logic [XLEN-1:0] s_result_q, s_result_d;
  logic            s_zero_q, s_zero_d;
  logic            s_illegal_q, s_illegal_d;

  logic            accept;
  logic            pop;
  logic [XLEN-1:0] new_result;
  logic            new_zero;
  logic            new_illegal;

  // Gating with rst keeps a buffered result from being handed out in the reset cycle.
  assign bus.in_ready  = !s_valid_q && !rst;
  assign bus.out_valid = r_valid_q && !rst;
  assign accept        = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  assign bus.result  = r_result_q;
  assign bus.zero    = r_zero_q;
  assign bus.illegal = r_illegal_q;

  always_comb begin
    new_result  = '0;
    new_illegal = 1'b0;
    unique case (bus.ALU_ctrl)
      3'b000:  new_result = bus.operand_a & bus.operand_b;
      3'b001:  new_result = bus.operand_a | bus.operand_b;
      3'b010:  new_result = bus.operand_a + bus.operand_b;
      3'b110:  new_result = bus.operand_a - bus.operand_b;
      default: new_illegal = 1'b1;
    endcase
    new_zero = (new_result == '0);
  end

  always_comb begin
    r_valid_d   = r_valid_q;
    r_result_d  = r_result_q;
    r_zero_d    = r_zero_q;
    r_illegal_d = r_illegal_q;
    s_valid_d   = s_valid_q;
    s_result_d  = s_result_q;
    s_zero_d    = s_zero_q;
    s_illegal_d = s_illegal_q;
    if (accept && (!r_valid_q || pop)) begin
      r_valid_d   = 1'b1;
      r_result_d  = new_result;
      r_zero_d    = new_zero;
      r_illegal_d = new_illegal;
    end else if (accept) begin
      s_valid_d   = 1'b1;
      s_result_d  = new_result;
      s_zero_d    = new_zero;
      s_illegal_d = new_illegal;
    end else if (pop && s_valid_q) begin
      r_result_d  = s_result_q;
      r_zero_d    = s_zero_q;
      r_illegal_d = s_illegal_q;
      s_valid_d   = 1'b0;
    end else if (pop) begin
      r_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_q   <= 1'b0;
      r_result_q  <= '0;
      r_zero_q    <= 1'b0;
      r_illegal_q <= 1'b0;
      s_valid_q   <= 1'b0;
      s_result_q  <= '0;
      s_zero_q    <= 1'b0;
      s_illegal_q <= 1'b0;
    end else begin
      r_valid_q   <= r_valid_d;
      r_result_q  <= r_result_d;
      r_zero_q    <= r_zero_d;
      r_illegal_q <= r_illegal_d;
      s_valid_q   <= s_valid_d;
      s_result_q  <= s_result_d;
      s_zero_q    <= s_zero_d;
      s_illegal_q <= s_illegal_d;
    end
  end

endmodule
